// File: rtl/seven_seg_scan_decoder.sv
// Receive-side monitor for a multiplexed 4-digit common-anode seven-segment bus.
// Captures settled digits per slot, then converts the BCD frame to binary and strobes it.
module seven_seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        anodeSelect0,
  input  logic        anodeSelect1,
  input  logic        anodeSelect2,
  input  logic        anodeSelect3,
  input  logic [6:0]  sevenSeg,
  output logic [15:0] digitCodes,
  output logic [13:0] value,
  output logic        frameValid,
  output logic        frameError
);

  typedef enum logic [1:0] {COLLECT, CONVERT, DONE} state_t;

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE_CYCLES);

  function automatic logic [3:0] segDecode(input logic [6:0] s);
    case (s)
      7'b1000000: segDecode = 4'h0;
      7'b1111001: segDecode = 4'h1;
      7'b0100100: segDecode = 4'h2;
      7'b0110000: segDecode = 4'h3;
      7'b0011001: segDecode = 4'h4;
      7'b0010010: segDecode = 4'h5;
      7'b0000010: segDecode = 4'h6;
      7'b1111000: segDecode = 4'h7;
      7'b0000000: segDecode = 4'h8;
      7'b0010000: segDecode = 4'h9;
      7'b1110111: segDecode = 4'hA;
      7'b1111111: segDecode = 4'hF;
      default:    segDecode = 4'hE;
    endcase
  endfunction

  // Assertion propagates immediately; release is delayed two CLK edges.
  logic [1:0] rstPipe;
  logic       rstN;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) rstPipe <= '0;
    else        rstPipe <= {rstPipe[0], 1'b1};
  end

  assign rstN = rstPipe[1];

  logic [3:0]  anodes;
  logic [10:0] curPat;
  logic [10:0] prevPat;
  logic [7:0]  settleCnt;
  logic        oneHot;
  logic [1:0]  slotIdx;
  logic        capture;
  logic [3:0]  capMask;
  logic [15:0] slotReg;
  logic [15:0] slotNext;
  logic [3:0]  seen;

  assign anodes = {anodeSelect3, anodeSelect2, anodeSelect1, anodeSelect0};
  assign curPat = {anodes, sevenSeg};

  always_comb begin
    oneHot  = 1'b1;
    slotIdx = 2'd0;
    case (anodes)
      4'b1110: slotIdx = 2'd0;
      4'b1101: slotIdx = 2'd1;
      4'b1011: slotIdx = 2'd2;
      4'b0111: slotIdx = 2'd3;
      default: oneHot  = 1'b0;
    endcase
  end

  // The edge that would bring the count to SETTLE_CYCLES is the capture edge.
  assign capture = oneHot && (curPat == prevPat) && (settleCnt == SETTLE_CNT - 8'd1);
  assign capMask = capture ? (4'b0001 << slotIdx) : 4'b0000;

  always_comb begin
    slotNext = slotReg;
    if (capture) slotNext[{slotIdx, 2'b00} +: 4] = segDecode(sevenSeg);
  end

  always_ff @(posedge CLK or negedge rstN) begin
    if (!rstN) begin
      prevPat   <= '0;
      settleCnt <= '0;
      slotReg   <= '0;
    end else begin
      prevPat <= curPat;
      slotReg <= slotNext;
      if (!oneHot)                   settleCnt <= '0;
      else if (curPat != prevPat)    settleCnt <= 8'd1;
      else if (settleCnt != SETTLE_CNT) settleCnt <= settleCnt + 8'd1;
    end
  end

  state_t      state;
  state_t      stateNext;
  logic        snapshotEn;
  logic        convEn;
  logic        doneEn;
  logic [15:0] snap;
  logic [13:0] acc;
  logic [1:0]  step;
  logic [3:0]  nib;
  logic [3:0]  digit;
  logic        anyBad;

  always_comb begin
    stateNext  = state;
    snapshotEn = 1'b0;
    convEn     = 1'b0;
    doneEn     = 1'b0;
    case (state)
      COLLECT: begin
        if ((seen | capMask) == 4'hF) begin
          snapshotEn = 1'b1;
          stateNext  = CONVERT;
        end
      end
      CONVERT: begin
        convEn = 1'b1;
        if (step == 2'd3) stateNext = DONE;
      end
      DONE: begin
        doneEn    = 1'b1;
        stateNext = COLLECT;
      end
      default: stateNext = COLLECT;
    endcase
  end

  // step 0 selects slot3, so the most significant digit enters first.
  assign nib   = snap[{~step, 2'b00} +: 4];
  assign digit = (nib > 4'd9) ? 4'd0 : nib;

  always_comb begin
    anyBad = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (snap[4*i +: 4] > 4'd9) anyBad = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rstN) begin
    if (!rstN) begin
      state      <= COLLECT;
      seen       <= '0;
      snap       <= '0;
      acc        <= '0;
      step       <= '0;
      value      <= '0;
      digitCodes <= '0;
      frameError <= 1'b0;
      frameValid <= 1'b0;
    end else begin
      state      <= stateNext;
      frameValid <= doneEn;
      if (snapshotEn) begin
        snap <= slotNext;
        seen <= '0;
        acc  <= '0;
        step <= '0;
      end else begin
        seen <= seen | capMask;
      end
      if (convEn) begin
        acc  <= (acc << 3) + (acc << 1) + {10'b0, digit};
        step <= step + 2'd1;
      end
      if (doneEn) begin
        value      <= acc;
        digitCodes <= snap;
        frameError <= anyBad;
      end
    end
  end

endmodule
